// File: rtl/mix_sample_streamer.sv
// mix_sample_streamer: samples the 8-voice mixer sum at SAMPLE_HZ, recentres and scales it
// to signed 32-bit codec format, queues it in a small FIFO and issues one-cycle codec writes.
// Optional feature macro: MIX_DROP_COUNT_EN adds a saturating drop_count[7:0] output.
module mix_sample_streamer #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned SAMPLE_HZ  = 48_000,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned GAIN_SHIFT = 20
) (
    input  logic                     CLOCK_50,
    input  logic                     resetn,
    input  logic [31:0]              mix_down,
    input  logic                     audio_out_allowed,
    output logic                     write_audio_out,
    output logic [31:0]              left_channel_audio_out,
    output logic [31:0]              right_channel_audio_out,
    output logic [$clog2(DEPTH):0]   fifo_level
`ifdef MIX_DROP_COUNT_EN
    ,
    output logic [7:0]               drop_count
`endif
);

    localparam int unsigned DIV   = CLK_HZ / SAMPLE_HZ;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [CNT_W-1:0] div_cnt;
    logic             sample_tick_c;
    logic [11:0]      recentred_c;
    logic [31:0]      sample_c;

    logic [31:0]      fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             push_c;
    logic             pop_c;
    logic             drop_c;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             write_nxt;
    logic [31:0]      data_q;

    // Only the low 11 bits of the mixer bus carry the sum.
    logic unused_mix_hi;
    assign unused_mix_hi = ^mix_down[31:11];

    // Sample-rate divider: counts 0..DIV-1, tick on the last count.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            div_cnt <= '0;
        end else if (sample_tick_c) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    assign sample_tick_c = (div_cnt == CNT_W'(DIV - 1));

    // Recentre 0..2040 around 1020 and scale to codec full range.
    assign recentred_c = {1'b0, mix_down[10:0]} - 12'd1020;
    assign sample_c    = {{20{recentred_c[11]}}, recentred_c} << GAIN_SHIFT;

    // A full FIFO still accepts a sample when the head leaves on the same edge.
    assign push_c = sample_tick_c && ((level < LVL_W'(DEPTH)) || pop_c);
    assign drop_c = sample_tick_c && !push_c;

    // Sample FIFO storage, pointers and occupancy.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_c) begin
                fifo_mem[wr_ptr] <= sample_c;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Write-handshake FSM state register.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: pop in IDLE, strobe for one cycle, then give the codec a cycle to respond.
    always_comb begin
        state_nxt = state;
        write_nxt = 1'b0;
        pop_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if ((level != '0) && audio_out_allowed) begin
                    pop_c     = 1'b1;
                    write_nxt = 1'b1;
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: state_nxt = ST_WAIT;
            ST_WAIT:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Registered write strobe and sample data; data holds between writes.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            write_audio_out <= 1'b0;
            data_q          <= '0;
        end else begin
            write_audio_out <= write_nxt;
            if (pop_c) begin
                data_q <= fifo_mem[rd_ptr];
            end
        end
    end

    assign left_channel_audio_out  = data_q;
    assign right_channel_audio_out = data_q;
    assign fifo_level              = level;

`ifdef MIX_DROP_COUNT_EN
    // Saturating count of samples lost to a full FIFO.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            drop_count <= '0;
        end else if (drop_c && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop_c;
`endif

endmodule

// File: tb/tb_mix_sample_streamer.sv
// Directed bench for mix_sample_streamer with a scoreboard queue of expected codec samples.
module tb_mix_sample_streamer;

    localparam int DIV = 10;

    logic        clk;
    logic        resetn;
    logic [31:0] mix_down;
    logic        audio_out_allowed;
    logic        write_audio_out;
    logic [31:0] left_out;
    logic [31:0] right_out;
    logic [2:0]  fifo_level;
`ifdef MIX_DROP_COUNT_EN
    logic [7:0]  drop_count;
`endif

    logic [31:0] exp_q[$];
    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int rel       = 0;
    int exp_drops = 0;

    mix_sample_streamer #(
        .CLK_HZ(1000), .SAMPLE_HZ(100), .DEPTH(4), .GAIN_SHIFT(20)
    ) dut (
        .CLOCK_50               (clk),
        .resetn                 (resetn),
        .mix_down               (mix_down),
        .audio_out_allowed      (audio_out_allowed),
        .write_audio_out        (write_audio_out),
        .left_channel_audio_out (left_out),
        .right_channel_audio_out(right_out),
        .fifo_level             (fifo_level)
`ifdef MIX_DROP_COUNT_EN
        ,
        .drop_count             (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Codec value for a mixer word: (low 11 bits - 1020) * 2^20, as 32-bit two's complement.
    function automatic logic [31:0] conv(input logic [31:0] m);
        int v;
        v = int'(m[10:0]) - 1020;
        return 32'(v * 1048576);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance one clock; any write pulse is matched against the oldest expected sample.
    task automatic step();
        logic [31:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (write_audio_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("write_with_no_sample", 32'(write_audio_out), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("left_data", left_out, e);
                check("right_data", right_out, e);
            end
        end
    endtask

    // Stop in the cycle whose closing edge is a sample tick.
    task automatic to_tick();
        while (((cyc - rel) % DIV) != DIV - 1) step();
    endtask

    task automatic do_tick(input logic [31:0] mix, input logic [31:0] exp_data,
                           input bit accept, input logic allow, input int exp_level);
        to_tick();
        mix_down          = mix;
        audio_out_allowed = allow;
        if (accept) exp_q.push_back(exp_data);
        else if (exp_drops < 255) exp_drops++;
        step();
        check("fifo_level", 32'(fifo_level), 32'(exp_level));
`ifdef MIX_DROP_COUNT_EN
        check("drop_count", 32'(drop_count), 32'(exp_drops));
`endif
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_write"}, 32'(write_audio_out), 32'd0);
        check({tag, "_left"}, left_out, 32'd0);
        check({tag, "_right"}, right_out, 32'd0);
        check({tag, "_level"}, 32'(fifo_level), 32'd0);
`ifdef MIX_DROP_COUNT_EN
        check({tag, "_drops"}, 32'(drop_count), 32'd0);
`endif
    endtask

    initial begin
        // Reset with random inputs
        resetn            = 1'b0;
        mix_down          = $urandom;
        audio_out_allowed = 1'($urandom_range(0, 1));
        repeat (5) begin
            step();
            check_idle_outputs("reset");
            mix_down          = $urandom;
            audio_out_allowed = 1'($urandom_range(0, 1));
        end
        resetn            = 1'b1;
        mix_down          = 32'd2040;
        audio_out_allowed = 1'b1;
        rel               = cyc;
        step();
        check_idle_outputs("post_reset");

        // Full scale: tick in cycle 10, pulse two cycles later, then every 10 cycles
        do_tick(32'd2040, 32'h3FC0_0000, 1'b1, 1'b1, 1);
        check("no_write_at_tick", 32'(write_audio_out), 32'd0);
        step();
        check("first_pulse", 32'(write_audio_out), 32'd1);
        do_tick(32'd2040, 32'h3FC0_0000, 1'b1, 1'b1, 1);
        step();
        check("second_pulse", 32'(write_audio_out), 32'd1);

        // Extremes and ignored upper bits
        do_tick(32'd0,          32'hC040_0000, 1'b1, 1'b1, 1);
        do_tick(32'd1020,       32'h0000_0000, 1'b1, 1'b1, 1);
        do_tick(32'hFFFF_F800,  32'hC040_0000, 1'b1, 1'b1, 1);

        // Backpressure: six ticks, last two dropped
        do_tick(32'd100, conv(32'd100), 1'b1, 1'b0, 1);
        do_tick(32'd200, conv(32'd200), 1'b1, 1'b0, 2);
        do_tick(32'd300, conv(32'd300), 1'b1, 1'b0, 3);
        do_tick(32'd400, conv(32'd400), 1'b1, 1'b0, 4);
        do_tick(32'd500, conv(32'd500), 1'b0, 1'b0, 4);
        do_tick(32'd600, conv(32'd600), 1'b0, 1'b0, 4);
        audio_out_allowed = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            check("drain_spacing", 32'(write_audio_out), (k % 3 == 1) ? 32'd1 : 32'd0);
        end
        do_tick(32'd700, conv(32'd700), 1'b1, 1'b1, 1);
        check("pop_on_tick_edge", 32'(write_audio_out), 32'd1);

        // Full FIFO: pop and push on the same edge
        do_tick(32'd800,  conv(32'd800),  1'b1, 1'b0, 1);
        do_tick(32'd900,  conv(32'd900),  1'b1, 1'b0, 2);
        do_tick(32'd1000, conv(32'd1000), 1'b1, 1'b0, 3);
        do_tick(32'd1100, conv(32'd1100), 1'b1, 1'b0, 4);
        do_tick(32'd1200, conv(32'd1200), 1'b1, 1'b1, 4);
        check("push_pop_write", 32'(write_audio_out), 32'd1);

        // Reset during a WRITE cycle with three samples queued
        do_tick(32'd1300, conv(32'd1300), 1'b1, 1'b0, 2);
        do_tick(32'd1400, conv(32'd1400), 1'b1, 1'b0, 3);
        do_tick(32'd1500, conv(32'd1500), 1'b1, 1'b0, 4);
        audio_out_allowed = 1'b1;
        step();
        check("write_before_reset", 32'(write_audio_out), 32'd1);
        check("level_before_reset", 32'(fifo_level), 32'd3);
        resetn = 1'b0;
        step();
        check_idle_outputs("mid_reset");
        exp_q.delete();
        exp_drops = 0;
        resetn    = 1'b1;
        rel       = cyc;
        mix_down  = 32'd2000;
        for (int k = 1; k <= DIV - 1; k++) begin
            step();
            check("level_before_first_tick", 32'(fifo_level), 32'd0);
        end
        exp_q.push_back(conv(32'd2000));
        step();
        check("level_after_first_tick", 32'(fifo_level), 32'd1);
        check("no_write_after_first_tick", 32'(write_audio_out), 32'd0);
        step();
        check("pulse_after_reset", 32'(write_audio_out), 32'd1);

        repeat (3) step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
